// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: after a block lands, scans the playfield bitmap
// bottom-up, removes full rows, compacts the surviving rows downward and
// zero-fills the rows freed at the top. Owns the bitmap port while busy.
// Optional macro LINE_CLEAR_SCORE_EN adds a saturating score accumulator.
module line_clear_sequencer #(
   parameter int AREA_ROW   = 32,
   parameter int AREA_COL   = 16,
   parameter int ROW_ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rstn,          // active-high async reset
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [2:0]              cancel_number,
   output logic [ROW_ADDR_W-1:0]   rd_row,
   input  logic [AREA_COL*2-1:0]   rd_data,
   output logic                    wr_en,
   output logic [ROW_ADDR_W-1:0]   wr_row,
   output logic [AREA_COL*2-1:0]   wr_data,
   output logic                    hold_fall
`ifdef LINE_CLEAR_SCORE_EN
   ,
   output logic [9:0]              score
`endif
);

   // Row pointers carry one extra bit so that stepping below row 0 sets the MSB.
   localparam int              PTR_W   = ROW_ADDR_W + 1;
   localparam logic [PTR_W-1:0] TOP_ROW = PTR_W'(AREA_ROW - 1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EVAL,
      S_FILL,
      S_DONE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [PTR_W-1:0] r_src, r_dst;
   logic [PTR_W-1:0] w_src_nxt, w_dst_nxt;
   logic [PTR_W-1:0] w_src_dec, w_dst_dec;
   logic [2:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [2:0]       r_cancel;
   logic             w_full;

   assign w_src_dec = r_src - PTR_ONE;
   assign w_dst_dec = r_dst - PTR_ONE;
   assign w_cnt_inc = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;

   // A row is full when every 2-bit cell holds a non-zero value.
   always_comb begin
      w_full = 1'b1;
      for (int c = 0; c < AREA_COL; c++) begin
         if (rd_data[2*c +: 2] == 2'b00) w_full = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rstn) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      if (rstn) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state, pointer updates and the bitmap write port.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_cnt_nxt   = r_cnt;
      wr_en       = 1'b0;
      wr_row      = '0;
      wr_data     = '0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_READ;
               w_src_nxt   = TOP_ROW;
               w_dst_nxt   = TOP_ROW;
               w_cnt_nxt   = 3'd0;
            end
         end

         S_READ: w_state_nxt = S_EVAL;

         S_EVAL: begin
            w_src_nxt = w_src_dec;
            if (w_full) begin
               w_cnt_nxt = w_cnt_inc;
            end else begin
               w_dst_nxt = w_dst_dec;
               // Once a full row has been skipped, survivors move down to dst.
               if (r_dst != r_src) begin
                  wr_en   = 1'b1;
                  wr_row  = r_dst[ROW_ADDR_W-1:0];
                  wr_data = rd_data;
               end
            end
            if (w_src_dec[ROW_ADDR_W])
               w_state_nxt = (w_cnt_nxt != 3'd0) ? S_FILL : S_DONE;
            else
               w_state_nxt = S_READ;
         end

         S_FILL: begin
            wr_en     = 1'b1;
            wr_row    = r_dst[ROW_ADDR_W-1:0];
            w_dst_nxt = w_dst_dec;
            if (w_dst_dec[ROW_ADDR_W]) w_state_nxt = S_DONE;
         end

         S_DONE: w_state_nxt = S_IDLE;

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pass datapath registers: scan pointers and full-row counter.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_src <= TOP_ROW;
         r_dst <= '0;
         r_cnt <= 3'd0;
      end else begin
         r_src <= w_src_nxt;
         r_dst <= w_dst_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // Hold the row count of the last completed pass.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)                   r_cancel <= 3'd0;
      else if (r_state == S_DONE) r_cancel <= r_cnt;
   end

   assign busy          = (r_state != S_IDLE);
   assign hold_fall     = busy;
   assign done          = (r_state == S_DONE);
   // The new count is already visible during the DONE cycle itself.
   assign cancel_number = done ? r_cnt : r_cancel;
   assign rd_row        = r_src[ROW_ADDR_W-1:0];

`ifdef LINE_CLEAR_SCORE_EN
   logic [9:0]  r_score;
   logic [9:0]  w_score_add;
   logic [10:0] w_score_sum;

   // Scoring table lookup for the rows cleared in this pass.
   always_comb begin
      case (r_cnt)
         3'd0:    w_score_add = 10'd0;
         3'd1:    w_score_add = 10'd1;
         3'd2:    w_score_add = 10'd10;
         3'd3:    w_score_add = 10'd66;
         default: w_score_add = 10'd100;
      endcase
      w_score_sum = {1'b0, r_score} + {1'b0, w_score_add};
   end

   // Accumulate in the DONE cycle, saturating at 999.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)
         r_score <= 10'd0;
      else if (r_state == S_DONE)
         r_score <= (w_score_sum > 11'd999) ? 10'd999 : w_score_sum[9:0];
   end

   assign score = r_score;
`endif

endmodule
